// File: rtl/argument_encoder_if.sv
// Field-push / word-emit bundle of the argument encoder.
// slave faces the encoder; master faces the upstream producer and downstream sink.
interface argument_encoder_if #(
  parameter int WIDTH_IN  = 64,
  parameter int WIDTH_OUT = 64
);
  localparam int LOG2_WIDTH_IN     = $clog2(WIDTH_IN);
  localparam int LOG2_BUFFER_WIDTH = $clog2(WIDTH_OUT + WIDTH_IN);

  logic                         push;
  logic [WIDTH_IN-1:0]          d;
  logic [LOG2_WIDTH_IN:0]       len;
  logic                         flush;
  logic                         out_stall;
  logic [WIDTH_OUT-1:0]         q;
  logic                         q_valid;
  logic                         full;
  logic                         flush_done;
  logic [LOG2_BUFFER_WIDTH:0]   count;

  modport master (
    output push, d, len, flush, out_stall,
    input  q, q_valid, full, flush_done, count
  );

  modport slave (
    input  push, d, len, flush, out_stall,
    output q, q_valid, full, flush_done, count
  );
endinterface

// File: rtl/argument_encoder.sv
// Packs variable-length fields MSB-first into a left-justified buffer and emits
// fixed-width words; flush zero-pads the tail word and pulses flush_done.
module argument_encoder #(
  parameter int WIDTH_IN          = 64,
  parameter int WIDTH_OUT         = 64,
  parameter int LOG2_WIDTH_IN     = $clog2(WIDTH_IN),
  parameter int BUFFER_WIDTH      = WIDTH_OUT + WIDTH_IN,
  parameter int LOG2_BUFFER_WIDTH = $clog2(BUFFER_WIDTH)
) (
  input logic             clk,
  input logic             rst,
  argument_encoder_if.slave bus
);

  localparam int CW = LOG2_BUFFER_WIDTH + 1;
  localparam int LW = LOG2_WIDTH_IN + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [LW-1:0] len_t;
  localparam cnt_t WOUT_C = cnt_t'(WIDTH_OUT);
  localparam len_t WIN_C  = len_t'(WIDTH_IN);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [BUFFER_WIDTH-1:0] buf_r;
  cnt_t                    count_r;
  logic [WIDTH_OUT-1:0]    q_r;
  logic                    q_valid_r;
  logic                    full_r;
  logic                    flush_done_r;

  len_t                    len_eff_s;
  logic [WIDTH_IN-1:0]     mask_s;
  logic                    accept_s;
  logic                    emit_s;
  cnt_t                    base_s;
  logic [BUFFER_WIDTH-1:0] shifted_s;
  logic [BUFFER_WIDTH-1:0] field_s;
  logic [BUFFER_WIDTH-1:0] buf_next_s;
  cnt_t                    count_next_s;

  // Next buffer image: optional word removal, then the new field placed right below the survivors.
  always_comb begin
    len_eff_s    = (bus.len > WIN_C) ? WIN_C : bus.len;
    mask_s       = {WIDTH_IN{1'b1}} >> (WIDTH_IN - int'(len_eff_s));
    accept_s     = bus.push & ~full_r;
    emit_s       = ((state_r == RUN) || (state_r == DRAIN)) &&
                   (count_r >= WOUT_C) && !bus.out_stall;
    base_s       = emit_s ? (count_r - WOUT_C) : count_r;
    shifted_s    = emit_s ? (buf_r << WIDTH_OUT) : buf_r;
    field_s      = accept_s ? {{(BUFFER_WIDTH-WIDTH_IN){1'b0}}, bus.d & mask_s}
                            : {BUFFER_WIDTH{1'b0}};
    // base+len never exceeds BUFFER_WIDTH when a field is accepted, so the shift is non-negative
    buf_next_s   = shifted_s |
                   (field_s << (BUFFER_WIDTH - int'(base_s) - int'(len_eff_s)));
    count_next_s = base_s + (accept_s ? cnt_t'(len_eff_s) : cnt_t'(0));
  end

  // Control FSM with registered buffer, word and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      buf_r        <= {BUFFER_WIDTH{1'b0}};
      count_r      <= cnt_t'(0);
      q_r          <= {WIDTH_OUT{1'b0}};
      q_valid_r    <= 1'b0;
      full_r       <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      buf_r        <= buf_next_s;
      count_r      <= count_next_s;
      q_valid_r    <= emit_s;
      flush_done_r <= 1'b0;
      if (emit_s) begin
        q_r <= buf_r[BUFFER_WIDTH-1 -: WIDTH_OUT];
      end else begin
        q_r <= q_r;
      end
      case (state_r)
        RUN: begin
          if (bus.flush) begin
            state_r <= DRAIN;
            full_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            full_r  <= (count_next_s > WOUT_C);
          end
        end
        DRAIN: begin
          full_r <= 1'b1;
          if (count_r < WOUT_C) begin
            state_r <= (count_r == cnt_t'(0)) ? DONE : PAD;
          end else begin
            state_r <= DRAIN;
          end
        end
        PAD: begin
          full_r <= 1'b1;
          if (!bus.out_stall) begin
            // tail bits are already left-justified with zeros below them
            q_r       <= buf_r[BUFFER_WIDTH-1 -: WIDTH_OUT];
            q_valid_r <= 1'b1;
            buf_r     <= {BUFFER_WIDTH{1'b0}};
            count_r   <= cnt_t'(0);
            state_r   <= DONE;
          end else begin
            state_r <= PAD;
          end
        end
        DONE: begin
          flush_done_r <= 1'b1;
          state_r      <= RUN;
          full_r       <= (count_next_s > WOUT_C);
        end
        default: begin
          state_r <= RUN;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid_r;
  assign bus.full       = full_r;
  assign bus.flush_done = flush_done_r;
  assign bus.count      = count_r;

endmodule

// File: tb/tb_argument_encoder.sv
// Directed bench for argument_encoder (16-bit fields/words) with a bit-queue stream model
// checked every cycle, plus literal expectations from hand-worked vectors.
module tb_argument_encoder;
  localparam int WI = 16;
  localparam int WO = 16;
  localparam int BW = WI + WO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  argument_encoder_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

  argument_encoder #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef enum int {M_RUN, M_DRAIN, M_PAD, M_DONE} mode_t;
  mode_t           mode = M_RUN;
  bit              sbits[$];
  logic [WO-1:0]   exp_q = '0;
  bit              exp_qv = 1'b0;
  bit              exp_fd = 1'b0;
  bit              exp_full = 1'b0;
  int              exp_count = 0;
  bit              armed = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: advances on the inputs the next rising edge will sample.
  task automatic model_step();
    int  sz0;
    int  l;
    bit  cur_full;
    bit  emit;
    logic [WO-1:0] w;
    if (rst) begin
      sbits.delete();
      mode   = M_RUN;
      exp_q  = '0;
      exp_qv = 1'b0;
      exp_fd = 1'b0;
    end else begin
      sz0      = sbits.size();
      cur_full = (mode != M_RUN) || (sz0 > WO);
      emit     = (mode == M_RUN || mode == M_DRAIN) && (sz0 >= WO) && !bus.out_stall;
      exp_qv   = 1'b0;
      exp_fd   = 1'b0;
      if (emit) begin
        for (int i = WO - 1; i >= 0; i--) exp_q[i] = sbits.pop_front();
        exp_qv = 1'b1;
      end
      if (bus.push && !cur_full) begin
        l = (int'(bus.len) > WI) ? WI : int'(bus.len);
        for (int i = l - 1; i >= 0; i--) sbits.push_back(bus.d[i]);
      end
      case (mode)
        M_RUN:   if (bus.flush) mode = M_DRAIN;
        M_DRAIN: if (sz0 < WO) mode = (sz0 == 0) ? M_DONE : M_PAD;
        M_PAD: begin
          if (!bus.out_stall) begin
            w = '0;
            for (int i = 0; i < sbits.size(); i++) w[WO-1-i] = sbits[i];
            exp_q  = w;
            exp_qv = 1'b1;
            sbits.delete();
            mode = M_DONE;
          end
        end
        default: begin
          exp_fd = 1'b1;
          mode   = M_RUN;
        end
      endcase
    end
    exp_full  = (mode != M_RUN) || (sbits.size() > WO);
    exp_count = sbits.size();
  endtask

  // Compare DUT against model on the falling edge, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("m_q",          {48'd0, bus.q},        {48'd0, exp_q});
        chk("m_q_valid",    {63'd0, bus.q_valid},  {63'd0, exp_qv});
        chk("m_full",       {63'd0, bus.full},     {63'd0, exp_full});
        chk("m_flush_done", {63'd0, bus.flush_done}, {63'd0, exp_fd});
        chk("m_count",      {58'd0, bus.count},    64'(exp_count));
        chk("count_bound",  {63'd0, (int'(bus.count) <= BW)}, 64'd1);
      end
      model_step();
      armed = 1'b1;
    end
  end

  task automatic cyc(bit p, logic [15:0] dv, logic [4:0] lv, bit f, bit s);
    bus.push      = p;
    bus.d         = dv;
    bus.len       = lv;
    bus.flush     = f;
    bus.out_stall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.push = 1'b0; bus.d = '0; bus.len = '0; bus.flush = 1'b0; bus.out_stall = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    chk("rst_count", {58'd0, bus.count}, 64'd0);
    chk("rst_q", {48'd0, bus.q}, 64'd0);
    chk("rst_qv", {63'd0, bus.q_valid}, 64'd0);
    chk("rst_full", {63'd0, bus.full}, 64'd0);
    chk("rst_fd", {63'd0, bus.flush_done}, 64'd0);
    rst = 1'b0;

    // three fields forming one word 101_1_101010111100 = 0xBABC
    cyc(1'b1, 16'h0005, 5'd3, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 5'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0ABC, 5'd12, 1'b0, 1'b0);
    chk("t1_count16", {58'd0, bus.count}, 64'd16);
    chk("t1_noqv", {63'd0, bus.q_valid}, 64'd0);
    idle();
    chk("t1_q", {48'd0, bus.q}, 64'hBABC);
    chk("t1_qv", {63'd0, bus.q_valid}, 64'd1);
    chk("t1_count0", {58'd0, bus.count}, 64'd0);
    idle();

    // flush with a 2-bit tail
    cyc(1'b1, 16'h0003, 5'd2, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    chk("t2_full_drain", {63'd0, bus.full}, 64'd1);
    idle();
    chk("t2_full_pad", {63'd0, bus.full}, 64'd1);
    idle();
    chk("t2_q", {48'd0, bus.q}, 64'hC000);
    chk("t2_qv", {63'd0, bus.q_valid}, 64'd1);
    chk("t2_fd_early", {63'd0, bus.flush_done}, 64'd0);
    idle();
    chk("t2_fd", {63'd0, bus.flush_done}, 64'd1);
    chk("t2_full_rel", {63'd0, bus.full}, 64'd0);
    idle();

    // stalled output holds two words
    cyc(1'b1, 16'h1234, 5'd16, 1'b0, 1'b1);
    chk("t3_full16", {63'd0, bus.full}, 64'd0);
    cyc(1'b1, 16'h5678, 5'd16, 1'b0, 1'b1);
    chk("t3_full32", {63'd0, bus.full}, 64'd1);
    cyc(1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
    chk("t3_count32", {58'd0, bus.count}, 64'd32);
    idle();
    chk("t3_q1", {48'd0, bus.q}, 64'h1234);
    chk("t3_full_drop", {63'd0, bus.full}, 64'd0);
    idle();
    chk("t3_q2", {48'd0, bus.q}, 64'h5678);
    idle();

    // emit and push on the same edge
    cyc(1'b1, 16'hAAAA, 5'd16, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 5'd16, 1'b0, 1'b0);
    chk("t4_q", {48'd0, bus.q}, 64'hAAAA);
    chk("t4_count", {58'd0, bus.count}, 64'd16);
    idle();
    chk("t4_q2", {48'd0, bus.q}, 64'hFFFF);

    // garbage upper bits, zero-length no-op, oversized length
    cyc(1'b1, 16'hFFF1, 5'd4, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0);
    chk("t5_len0", {58'd0, bus.count}, 64'd4);
    cyc(1'b1, 16'hF123, 5'd12, 1'b0, 1'b0);
    idle();
    chk("t5_q", {48'd0, bus.q}, 64'h1123);
    cyc(1'b1, 16'hBEEF, 5'd20, 1'b0, 1'b0);
    chk("t5_clamp", {58'd0, bus.count}, 64'd16);
    idle();
    chk("t5_q2", {48'd0, bus.q}, 64'hBEEF);

    // back-to-back full words
    cyc(1'b1, 16'h1111, 5'd16, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 5'd16, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 5'd16, 1'b0, 1'b0);
    chk("tp_q", {48'd0, bus.q}, 64'h2222);
    idle();
    idle();

    // flush on an empty buffer
    cyc(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    idle();
    idle();
    chk("ef_fd", {63'd0, bus.flush_done}, 64'd1);
    idle();

    // reset in the middle of a drain
    cyc(1'b1, 16'h01FF, 5'd9, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 16'hFFFF, 5'd16, 1'b1, 1'b1);
    rst = 1'b0;
    chk("t6_count", {58'd0, bus.count}, 64'd0);
    chk("t6_full", {63'd0, bus.full}, 64'd0);
    chk("t6_qv", {63'd0, bus.q_valid}, 64'd0);
    cyc(1'b1, 16'h0001, 5'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 5'd15, 1'b0, 1'b0);
    idle();
    chk("t6_q", {48'd0, bus.q}, 64'h8000);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/argument_encoder.md
Name: argument_encoder

Overview:
Bit-packing encoder, the transmit-side counterpart of the argument decoder path. Upstream logic pushes variable-length fields (value plus bit length) at up to one per cycle. The block packs them MSB-first into a contiguous bit stream and emits fixed-width WIDTH_OUT words toward a downstream FIFO. A flush command pads the final partial word with zeros and reports completion.

Parameters:
WIDTH_IN, 64, maximum field width in bits; fields are right-justified in d
WIDTH_OUT, 64, emitted word width in bits
LOG2_WIDTH_IN, log2(WIDTH_IN), field-length index width
BUFFER_WIDTH, WIDTH_OUT + WIDTH_IN, packing buffer size in bits
LOG2_BUFFER_WIDTH, log2(BUFFER_WIDTH), buffer index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
push  in  1  field valid; honoured only when full=0
d  in  WIDTH_IN  field value; only the low len bits are used
len  in  LOG2_WIDTH_IN+1  field length 0..WIDTH_IN
flush  in  1  single-cycle pulse requesting stream termination
out_stall  in  1  downstream cannot accept a word this cycle (e.g. FIFO almost_full)
q  out  WIDTH_OUT  packed word; first stream bit at q[WIDTH_OUT-1]
q_valid  out  1  q holds a new word this cycle (one-cycle pulse per word)
full  out  1  push not accepted this cycle
flush_done  out  1  one-cycle pulse when flush completes
count  out  LOG2_BUFFER_WIDTH+1  bits currently held in the buffer

Behaviour:
- Reset (rst=1 at an edge): count=0, buffer cleared, q=0, q_valid=0, flush_done=0, state=RUN. Reset overrides every other input, including in-flight flush, stall and push.
- Buffer:
  - BUFFER_WIDTH bits, left-justified. Valid bits occupy the top count positions.
  - An accepted field goes immediately below the existing valid bits, MSB of the field first.
  - d bits above len are ignored and must not corrupt the buffer.
- Field length:
  - len=0: accepted as a no-op; count is unchanged.
  - len>WIDTH_IN: treated as WIDTH_IN.
- full = (state!=RUN) OR (count > WIDTH_OUT). This guarantees room for a maximum field.
- Emit condition: count >= WIDTH_OUT AND out_stall=0.
  - At that edge: q <= top WIDTH_OUT buffer bits, q_valid <= 1, remaining bits shift to the top, count -= WIDTH_OUT.
  - Otherwise q_valid <= 0 and q holds its value.
- Emit and push in the same edge:
  - The new field is appended after the bits remaining post-shift.
  - count_next = count - WIDTH_OUT + len.
  - No bit is lost or duplicated.
- Latency: a push sampled at edge E that completes a word gives q_valid=1 after edge E+1, provided out_stall=0 in cycle E+1. Maximum throughput is one word per cycle.
- out_stall holds the data: the buffer is retained and emission resumes on the first non-stalled cycle, in original order.
- State machine:
  - RUN: normal packing. flush=1 moves to DRAIN. A push in the same cycle as flush is accepted and included in the stream.
  - DRAIN: full=1. Emit whole words as above. When count < WIDTH_OUT:
    - count=0: go to DONE.
    - count>0: go to PAD.
  - PAD: when out_stall=0, q <= remaining bits left-justified with zero fill below. q_valid <= 1, count <= 0, go to DONE. Stalls hold the state in PAD.
  - DONE: flush_done=1 for exactly one cycle, then back to RUN.
- Flush with an empty buffer goes RUN→DRAIN→DONE. No word is emitted; flush_done still pulses.
- flush while not in RUN: ignored.
- count never exceeds BUFFER_WIDTH. Exceeding it is a design error; the bench asserts on it.

Test Plan:
- WIDTH_IN=WIDTH_OUT=16. Push (0x5,len3), (0x1,len1), (0xABC,len12) on consecutive cycles, out_stall=0 → single q_valid pulse with q=0xBABC two edges after the last push; count=0 afterwards.
- WIDTH_IN=WIDTH_OUT=16. Push (0x3,len2), then flush → q=0xC000 q_valid pulse, then flush_done pulse on the following cycle; full=1 from flush until DONE.
- out_stall=1. Push (0x1234,16) and (0x5678,16) → full=1 after count reaches 32, no q_valid. Release stall → q=0x1234 then q=0x5678 on consecutive cycles; full drops when count<=16.
- count=16 with emit and push (0xFFFF,16) in the same edge → q=prior word, count stays 16; a subsequent emit gives q=0xFFFF.
- Push with garbage upper bits, e.g. d=0xFFF1 with len=4 → only nibble 0x1 enters the stream.
- Assert rst mid-DRAIN with count=9 → next cycle count=0, q_valid=0, flush_done=0, full=0, state RUN; a new push packs from bit 15.
